input_event_hub: RTL

INPUT_EVENT_HUB -- requirements
Module: input_event_hub

---
 rtl/input_event_pkg.sv | 18 +
 rtl/debounce_ch.sv | 38 +++
 rtl/input_event_hub.sv | 122 ++++++++++++
 3 files changed

// File: rtl/input_event_pkg.sv
// rtl/input_event_pkg.sv - event type encoding and code helper shared by the input event hub.
package input_event_pkg;

  localparam int EVT_W = 8;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    BTN_PRESS   = 2'd0,
    BTN_RELEASE = 2'd1,
    CLK_PRESS   = 2'd2,
    CLK_RELEASE = 2'd3
  } evt_type_e;

  function automatic logic [EVT_W-1:0] make_code(input evt_type_e t, input logic [IDX_W-1:0] idx);
    return {t, idx};
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: 2-flop synchronizer, stability counter and stable level.
module debounce_ch #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYC);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any return to the stable level restarts the count, so glitches never accumulate.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_event_hub.sv
// rtl/input_event_hub.sv - button/click edge events into a priority-encoded FIFO; INPUT_EVENT_HUB_RELEASE_EVT_EN enables release events.
module input_event_hub
  import input_event_pkg::*;
#(
  parameter int N_BTN        = 2,
  parameter int N_CLK        = 4,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [N_BTN-1:0]            btn_raw,
  input  logic [N_CLK-1:0]            click_raw,
  output logic [N_BTN-1:0]            btn_level,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [EVT_W-1:0]            evt_code,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        overflow
);

  localparam int N_SRC  = N_BTN + N_CLK;
  localparam int N_PEND = 2 * N_SRC;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

`ifdef INPUT_EVENT_HUB_RELEASE_EVT_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  logic [N_BTN-1:0]  btn_stable;
  logic [N_CLK-1:0]  clk_s1;
  logic [N_CLK-1:0]  clk_s2;
  logic [N_SRC-1:0]  lvl;
  logic [N_SRC-1:0]  lvl_d;
  logic [N_PEND-1:0] pend;
  logic [N_PEND-1:0] set;
  logic [N_PEND-1:0] clr;
  logic              hit;
  logic              push;
  logic              pop;
  int                sel;
  logic [EVT_W-1:0]  push_code;
  logic [EVT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    debounce_ch #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .Clk   (Clk),
      .Reset (Reset),
      .raw   (btn_raw[i]),
      .level (btn_stable[i])
    );
  end

  assign btn_level = btn_stable;
  assign lvl       = {clk_s2, btn_stable};

  // Pending bit 2*s is the press of source s, 2*s+1 its release; buttons occupy the low sources.
  always_comb begin
    set = '0;
    for (int s = 0; s < N_SRC; s++) begin
      set[2*s]   = lvl[s] & ~lvl_d[s];
      set[2*s+1] = ~lvl[s] & lvl_d[s] & REL_EN;
    end
  end

  // Lowest pending bit wins, which yields buttons first, low index first, press first.
  always_comb begin
    hit       = 1'b0;
    sel       = 0;
    push_code = '0;
    for (int p = N_PEND - 1; p >= 0; p--) begin
      if (pend[p]) begin
        hit       = 1'b1;
        sel       = p;
        push_code = make_code(evt_type_e'({1'(p >= 2 * N_BTN), p[0]}),
                              IDX_W'((p < 2 * N_BTN) ? p / 2 : p / 2 - N_BTN));
      end
    end
  end

  assign push      = hit && (evt_count < CW'(FIFO_DEPTH));
  assign clr       = push ? (N_PEND'(1) << sel) : '0;
  assign evt_valid = (evt_count != '0);
  assign pop       = evt_valid && evt_ready;
  assign evt_code  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1    <= '0;
      clk_s2    <= '0;
      lvl_d     <= '0;
      pend      <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else begin
      clk_s1 <= click_raw;
      clk_s2 <= clk_s1;
      lvl_d  <= lvl;
      pend   <= (pend & ~clr) | set;
      if (|(set & pend & ~clr)) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   evt_count <= evt_count + CW'(1);
        2'b01:   evt_count <= evt_count - CW'(1);
        default: evt_count <= evt_count;
      endcase
    end
  end

endmodule
